mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
Memory-access stage of the 5-stage RV64 pipeline. It sits between the EX/MEM register and the write-back stage, and owns the MEM/WB pipeline register.
- Issues loads/stores to a data-memory port using a req/ready handshake.
- Sign- or zero-extends load data, builds store byte strobes.
- Stalls upstream until each access completes.
- Drives RegWriteW, MemToRegW, ALU_ResultW, ReadDataW and RD_W into write-back.

Parameters:
XLEN, 64, datapath width; only 64 is supported.
STRB_W, XLEN/8, number of byte strobes.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  reset, synchronous, active-low.
ValidM  in  1  instruction present in M.
RegWriteM  in  1  instruction writes rd.
MemToRegM  in  1  write-back source is memory.
MemReadM  in  1  load.
MemWriteM  in  1  store.
Funct3M  in  3  access size/sign, RISC-V encoding.
ALU_ResultM  in  64  effective address, or ALU result for non-memory ops.
WriteDataM  in  64  store data (rs2).
RD_M  in  5  destination register.
StallM  out  1  hold EX/MEM and all earlier stages.
mem_req  out  1  memory request valid.
mem_we  out  1  1 = store.
mem_addr  out  64  doubleword-aligned address {ALU_ResultM[63:3],3'b0}.
mem_wdata  out  64  store data shifted into byte lanes.
mem_wstrb  out  8  byte enables (0 for loads).
mem_ready  in  1  memory accepts/completes the request this cycle.
mem_rdata  in  64  doubleword read data, valid when mem_ready=1.
RegWriteW  out  1  to write-back.
MemToRegW  out  1  to write-back.
ALU_ResultW  out  64  to write-back.
ReadDataW  out  64  extended load data.
RD_W  out  5  to write-back.
MisalignW  out  1  1-cycle flag: the access was misaligned or illegal.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE.
  - All W outputs are 0; mem_req=0; StallM=0.
  - Reset mid-access abandons the access; mem_req is low from the next cycle.
- memop = ValidM & (MemReadM | MemWriteM).
- Size: Funct3M[1:0] selects B/H/W/D = 1/2/4/8 bytes.
- Misaligned: offset=ALU_ResultM[2:0] is not a multiple of the size.
- Illegal: a store with Funct3M[2]=1, or a load with Funct3M=111.
- FSM states IDLE, WAIT:
  - IDLE, memop, legal and aligned: StallM=1, go to WAIT. A bubble enters WB (RegWriteW=0, MemToRegW=0, RD_W=0, data 0).
  - IDLE, memop, misaligned or illegal: no memory access, StallM=0. Next edge: MisalignW=1, RegWriteW=0, RD_W=0. Stay IDLE.
  - IDLE, non-memop: StallM=0. Next edge: W outputs take the M inputs (RegWriteW=RegWriteM&ValidM, ReadDataW=0).
  - WAIT: mem_req=1, mem_we=MemWriteM; address, wdata and wstrb are driven from the held M inputs.
    - mem_ready=0: StallM=1, a bubble enters WB, stay in WAIT.
    - mem_ready=1: StallM=0. Next edge: W outputs capture the instruction, ReadDataW=extended data, state returns to IDLE.
- Access latency is at least 2 cycles (one IDLE cycle plus one WAIT cycle). A non-memory op takes 1 cycle.
- Upstream holds the M inputs stable while StallM=1. mem_req is never asserted in IDLE. mem_ready is ignored in IDLE.
- Load extract:
  - lane = mem_rdata >> (8*offset).
  - Funct3 000 LB / 001 LH / 010 LW sign-extend from bit 7 / 15 / 31.
  - 011 LD passes the lane through.
  - 100 LBU / 101 LHU / 110 LWU zero-extend.
- Store:
  - mem_wdata = WriteDataM << (8*offset).
  - mem_wstrb = (2^size − 1) << offset; for SD it is 8'hFF.
- A store writes no register: RegWriteW follows RegWriteM, which decode sets to 0 for stores.

Decomposition:
- Package mem_pkg holds:
  - funct3 constants (LB..LWU, SB..SD);
  - the state enum {IDLE, WAIT};
  - size decode;
  - the misalignment function.
- Sub-module mem_load_align is combinational: (mem_rdata, offset, Funct3M) -> 64-bit extended data.
- The store lane/strobe logic stays inline.

Test Plan:
- Non-memory op: RegWriteM=1, RD_M=5, ALU_ResultM=0x1234 -> next cycle RegWriteW=1, RD_W=5, ALU_ResultW=0x1234, StallM never 1.
- LB at addr 0x1003, mem_rdata=0x0000_0000_80FF_0000, ready on the first WAIT cycle -> StallM=1 for 1 cycle, mem_addr=0x1000, then ReadDataW=0xFFFF_FFFF_FFFF_FF80, MemToRegW=1. The same case as LBU -> ReadDataW=0x80.
- SH at addr 0x2006, WriteDataM=0xABCD, mem_ready held low for 3 WAIT cycles -> mem_wstrb=8'hC0, mem_wdata=0xABCD_0000_0000_0000, StallM high for 4 cycles, a bubble in WB each stalled cycle.
- LW at addr 0x3002 -> no mem_req, StallM=0, next cycle MisalignW=1, RegWriteW=0. Store with Funct3M=100 -> the same response.
- rst_n=0 while in WAIT -> next cycle mem_req=0, StallM=0, all W outputs 0, state IDLE. A later LD at 0x4000 with mem_rdata=0x0123_4567_89AB_CDEF -> ReadDataW=0x0123_4567_89AB_CDEF.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings, state/size types and access-legality helpers for the RV64 memory stage.
package mem_pkg;

  localparam int unsigned XlenDef = 64;

  // Load funct3 encodings
  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Ld  = 3'b011;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;
  localparam logic [2:0] F3Lwu = 3'b110;

  // Store funct3 encodings
  localparam logic [2:0] F3Sb  = 3'b000;
  localparam logic [2:0] F3Sh  = 3'b001;
  localparam logic [2:0] F3Sw  = 3'b010;
  localparam logic [2:0] F3Sd  = 3'b011;

  typedef enum logic {
    StIdle,
    StWait
  } mem_state_e;

  typedef enum logic [1:0] {
    SizeB = 2'd0,
    SizeH = 2'd1,
    SizeW = 2'd2,
    SizeD = 2'd3
  } mem_size_e;

  // Everything handed to write-back lives in one register.
  typedef struct packed {
    logic               reg_write;
    logic               mem_to_reg;
    logic [XlenDef-1:0] alu_result;
    logic [XlenDef-1:0] read_data;
    logic [4:0]         rd;
    logic               misalign;
  } wb_t;

  function automatic mem_size_e decode_size(input logic [2:0] funct3);
    return mem_size_e'(funct3[1:0]);
  endfunction

  function automatic logic is_misaligned(input mem_size_e size, input logic [2:0] offset);
    logic mis;
    unique case (size)
      SizeB:   mis = 1'b0;
      SizeH:   mis = offset[0];
      SizeW:   mis = |offset[1:0];
      SizeD:   mis = |offset;
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

  // Stores have no unsigned variants; 3'b111 is not a load.
  function automatic logic is_illegal(input logic mem_read, input logic mem_write,
                                      input logic [2:0] funct3);
    return (mem_write & funct3[2]) | (mem_read & (funct3 == 3'b111));
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed bytes from a doubleword read and sign/zero-extends them per funct3.
module mem_load_align
  import mem_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [2:0]      offset_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  logic [XLEN-1:0] lane;

  assign lane = rdata_i >> {offset_i, 3'b000};

  always_comb begin
    data_o = lane;
    case (funct3_i)
      F3Lb:    data_o = {{(XLEN-8){lane[7]}}, lane[7:0]};
      F3Lh:    data_o = {{(XLEN-16){lane[15]}}, lane[15:0]};
      F3Lw:    data_o = {{(XLEN-32){lane[31]}}, lane[31:0]};
      F3Ld:    data_o = lane;
      F3Lbu:   data_o = {{(XLEN-8){1'b0}}, lane[7:0]};
      F3Lhu:   data_o = {{(XLEN-16){1'b0}}, lane[15:0]};
      F3Lwu:   data_o = {{(XLEN-32){1'b0}}, lane[31:0]};
      default: data_o = lane;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV64 MEM stage: issues data-memory accesses over req/ready, stalls upstream, owns MEM/WB.
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned STRB_W = XLEN / 8
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              ValidM,
  input  logic              RegWriteM,
  input  logic              MemToRegM,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [2:0]        Funct3M,
  input  logic [XLEN-1:0]   ALU_ResultM,
  input  logic [XLEN-1:0]   WriteDataM,
  input  logic [4:0]        RD_M,
  output logic              StallM,

  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic              mem_ready,
  input  logic [XLEN-1:0]   mem_rdata,

  output logic              RegWriteW,
  output logic              MemToRegW,
  output logic [XLEN-1:0]   ALU_ResultW,
  output logic [XLEN-1:0]   ReadDataW,
  output logic [4:0]        RD_W,
  output logic              MisalignW
);

  mem_state_e        state_q, state_d;
  wb_t               wb_q, wb_d;
  logic              memop;
  logic              access_bad;
  logic              stall;
  mem_size_e         size;
  logic [2:0]        offset;
  logic [XLEN-1:0]   load_data;
  logic [STRB_W-1:0] strb_base;

  assign memop      = ValidM & (MemReadM | MemWriteM);
  assign size       = decode_size(Funct3M);
  assign offset     = ALU_ResultM[2:0];
  assign access_bad = is_misaligned(size, offset) | is_illegal(MemReadM, MemWriteM, Funct3M);

  mem_load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .rdata_i (mem_rdata),
    .offset_i(offset),
    .funct3_i(Funct3M),
    .data_o  (load_data)
  );

  // Default is a bubble into WB; only a completing instruction overrides it.
  always_comb begin
    state_d = state_q;
    wb_d    = '0;
    stall   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (memop) begin
          if (access_bad) begin
            wb_d.misalign = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = StWait;
          end
        end else begin
          wb_d.reg_write  = RegWriteM & ValidM;
          wb_d.mem_to_reg = MemToRegM;
          wb_d.alu_result = ALU_ResultM;
          wb_d.rd         = RD_M;
        end
      end
      StWait: begin
        if (mem_ready) begin
          state_d         = StIdle;
          wb_d.reg_write  = RegWriteM & ValidM;
          wb_d.mem_to_reg = MemToRegM;
          wb_d.alu_result = ALU_ResultM;
          wb_d.read_data  = load_data;
          wb_d.rd         = RD_M;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      wb_q    <= wb_d;
    end
  end

  // Upstream must not see a stall while the stage is being reset.
  assign StallM = rst_n & stall;

  always_comb begin
    unique case (size)
      SizeB:   strb_base = STRB_W'(8'h01);
      SizeH:   strb_base = STRB_W'(8'h03);
      SizeW:   strb_base = STRB_W'(8'h0F);
      SizeD:   strb_base = STRB_W'(8'hFF);
      default: strb_base = '0;
    endcase
  end

  assign mem_req   = (state_q == StWait);
  assign mem_we    = mem_req & MemWriteM;
  assign mem_addr  = {ALU_ResultM[XLEN-1:3], 3'b000};
  assign mem_wdata = mem_we ? (WriteDataM << {offset, 3'b000}) : '0;
  assign mem_wstrb = mem_we ? (strb_base << offset) : '0;

  assign RegWriteW   = wb_q.reg_write;
  assign MemToRegW   = wb_q.mem_to_reg;
  assign ALU_ResultW = wb_q.alu_result;
  assign ReadDataW   = wb_q.read_data;
  assign RD_W        = wb_q.rd;
  assign MisalignW   = wb_q.misalign;

endmodule

// File: tb/tb_mem_stage.sv
// Randomised bench for mem_stage with an instruction-level reference model and directed pins.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ValidM, RegWriteM, MemToRegM, MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [63:0] ALU_ResultM, WriteDataM;
  logic [4:0]  RD_M;
  logic        StallM;
  logic        mem_req, mem_we, mem_ready;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wstrb;
  logic        RegWriteW, MemToRegW, MisalignW;
  logic [63:0] ALU_ResultW, ReadDataW;
  logic [4:0]  RD_W;

  mem_stage #(.XLEN(64), .STRB_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .ValidM(ValidM), .RegWriteM(RegWriteM), .MemToRegM(MemToRegM), .MemReadM(MemReadM),
    .MemWriteM(MemWriteM), .Funct3M(Funct3M), .ALU_ResultM(ALU_ResultM),
    .WriteDataM(WriteDataM), .RD_M(RD_M), .StallM(StallM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .RegWriteW(RegWriteW), .MemToRegW(MemToRegW), .ALU_ResultW(ALU_ResultW),
    .ReadDataW(ReadDataW), .RD_W(RD_W), .MisalignW(MisalignW)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw;
    logic        m2r;
    logic [63:0] alu;
    logic [63:0] rdat;
    logic [4:0]  rd;
    logic        mis;
  } w_t;

  w_t          exp_w = '0;
  w_t          exp_w_nxt = '0;
  logic        exp_stall = 1'b0, exp_req = 1'b0, exp_we = 1'b0;
  logic [63:0] exp_addr = '0, exp_wdata = '0;
  logic [7:0]  exp_wstrb = '0;
  bit          chk_en = 1'b0, chk_comb = 1'b0;
  int          n_chk = 0, n_fail = 0;
  int          stall_cnt = 0;
  logic [63:0] seen_addr = '0, seen_wdata = '0;
  logic [7:0]  seen_wstrb = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference load extraction: pick bytes from the offset, then extend by width and sign.
  function automatic logic [63:0] load_ext(input logic [63:0] rdata, input logic [2:0] f3,
                                           input int off);
    logic [63:0] lane, mask;
    int bits;
    lane = rdata >> (8 * off);
    bits = 8 << f3[1:0];
    if (bits == 64) return lane;
    mask = (64'd1 << bits) - 64'd1;
    lane = lane & mask;
    if (!f3[2] && lane[bits-1]) lane = lane | ~mask;
    return lane;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("RegWriteW", 64'(RegWriteW), 64'(exp_w.rw));
      chk("MemToRegW", 64'(MemToRegW), 64'(exp_w.m2r));
      chk("ALU_ResultW", ALU_ResultW, exp_w.alu);
      chk("ReadDataW", ReadDataW, exp_w.rdat);
      chk("RD_W", 64'(RD_W), 64'(exp_w.rd));
      chk("MisalignW", 64'(MisalignW), 64'(exp_w.mis));
      if (chk_comb) begin
        chk("StallM", 64'(StallM), 64'(exp_stall));
        chk("mem_req", 64'(mem_req), 64'(exp_req));
        chk("mem_we", 64'(mem_we), 64'(exp_we));
        chk("mem_wdata", mem_wdata, exp_wdata);
        chk("mem_wstrb", 64'(mem_wstrb), 64'(exp_wstrb));
        if (exp_req) chk("mem_addr", mem_addr, exp_addr);
      end
      if (StallM === 1'b1) stall_cnt++;
      if (mem_req === 1'b1) begin
        seen_addr  = mem_addr;
        seen_wdata = mem_wdata;
        seen_wstrb = mem_wstrb;
      end
    end
  end

  task automatic begin_cycle();
    @(posedge clk);
    exp_w = exp_w_nxt;
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r, input logic rdm,
                       input logic wrm, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd, input logic [4:0] rd);
    ValidM = v; RegWriteM = rw; MemToRegM = m2r; MemReadM = rdm; MemWriteM = wrm;
    Funct3M = f3; ALU_ResultM = a; WriteDataM = wd; RD_M = rd;
  endtask

  task automatic set_idle_exp();
    chk_comb = 1'b1; exp_stall = 1'b0; exp_req = 1'b0; exp_we = 1'b0;
    exp_wdata = '0; exp_wstrb = '0;
  endtask

  // One instruction held for as many cycles as the model says it occupies; k = not-ready cycles.
  task automatic run_instr(input logic v, input logic rw, input logic m2r, input logic rdm,
                           input logic wrm, input logic [2:0] f3, input logic [63:0] a,
                           input logic [63:0] wd, input logic [4:0] rd, input int k,
                           input logic [63:0] rdata);
    int  nbytes, off;
    bit  memop, bad;
    nbytes = 1 << f3[1:0];
    off    = int'(a[2:0]);
    memop  = v && (rdm || wrm);
    bad    = (off % nbytes != 0) || (wrm && f3[2]) || (rdm && f3 == 3'b111);
    begin_cycle();
    rst_n = 1'b1;
    drive(v, rw, m2r, rdm, wrm, f3, a, wd, rd);
    mem_ready = 1'($urandom);
    mem_rdata = {$urandom, $urandom};
    set_idle_exp();
    if (!memop) begin
      exp_w_nxt = '{rw & v, m2r, a, 64'd0, rd, 1'b0};
    end else if (bad) begin
      exp_w_nxt = '{1'b0, 1'b0, 64'd0, 64'd0, 5'd0, 1'b1};
    end else begin
      exp_stall = 1'b1;
      exp_w_nxt = '0;
      for (int i = 0; i <= k; i++) begin
        begin_cycle();
        mem_ready = (i == k);
        mem_rdata = (i == k) ? rdata : {$urandom, $urandom};
        exp_req   = 1'b1;
        exp_we    = wrm;
        exp_addr  = a & ~64'd7;
        exp_wdata = wrm ? (wd << (8 * off)) : 64'd0;
        exp_wstrb = wrm ? 8'(((1 << nbytes) - 1) << off) : 8'd0;
        exp_stall = (i != k);
        exp_w_nxt = (i == k) ? w_t'{rw & v, m2r, a, load_ext(rdata, f3, off), rd, 1'b0} : '0;
      end
    end
  endtask

  task automatic run_nop();
    run_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 64'd0, 64'd0, 5'd0, 0, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 64'd0, 64'd0, 5'd0);
    mem_ready = 1'b0;
    mem_rdata = '0;
    begin_cycle();
    chk_en = 1'b1;
    begin_cycle();
    @(negedge clk);
    chk("reset RegWriteW", 64'(RegWriteW), 64'd0);
    chk("reset ReadDataW", ReadDataW, 64'd0);
    chk("reset mem_req", 64'(mem_req), 64'd0);
    chk("reset StallM", 64'(StallM), 64'd0);

    // Non-memory op
    stall_cnt = 0;
    run_instr(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 64'h1234, 64'd0, 5'd5, 0, 64'd0);
    run_nop();
    @(negedge clk);
    chk("alu RegWriteW", 64'(RegWriteW), 64'd1);
    chk("alu RD_W", 64'(RD_W), 64'd5);
    chk("alu ALU_ResultW", ALU_ResultW, 64'h1234);
    chk("alu stall cycles", 64'(stall_cnt), 64'd0);

    // LB / LBU at 0x1003
    stall_cnt = 0;
    run_instr(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 64'h1003, 64'd0, 5'd7, 0, 64'h80FF_0000);
    run_nop();
    @(negedge clk);
    chk("LB ReadDataW", ReadDataW, 64'hFFFF_FFFF_FFFF_FF80);
    chk("LB MemToRegW", 64'(MemToRegW), 64'd1);
    chk("LB mem_addr", seen_addr, 64'h1000);
    chk("LB stall cycles", 64'(stall_cnt), 64'd1);
    run_instr(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b100, 64'h1003, 64'd0, 5'd7, 0, 64'h80FF_0000);
    run_nop();
    @(negedge clk);
    chk("LBU ReadDataW", ReadDataW, 64'h80);

    // SH at 0x2006 with three not-ready cycles
    stall_cnt = 0;
    run_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 64'h2006, 64'hABCD, 5'd0, 3, 64'd0);
    run_nop();
    @(negedge clk);
    chk("SH mem_wstrb", 64'(seen_wstrb), 64'hC0);
    chk("SH mem_wdata", seen_wdata, 64'hABCD_0000_0000_0000);
    chk("SH stall cycles", 64'(stall_cnt), 64'd4);

    // Misaligned LW, illegal store
    run_instr(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 64'h3002, 64'd0, 5'd3, 0, 64'd0);
    run_nop();
    @(negedge clk);
    chk("LW misalign MisalignW", 64'(MisalignW), 64'd1);
    chk("LW misalign RegWriteW", 64'(RegWriteW), 64'd0);
    run_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b100, 64'h3000, 64'h55, 5'd0, 0, 64'd0);
    run_nop();
    @(negedge clk);
    chk("illegal store MisalignW", 64'(MisalignW), 64'd1);

    // Reset while waiting on memory, then a clean LD
    begin_cycle();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b011, 64'h4000, 64'd0, 5'd9);
    set_idle_exp();
    exp_stall = 1'b1;
    exp_w_nxt = '0;
    begin_cycle();
    mem_ready = 1'b0;
    exp_stall = 1'b1; exp_req = 1'b1; exp_addr = 64'h4000;
    begin_cycle();
    rst_n = 1'b0;
    chk_comb = 1'b0;
    exp_w_nxt = '0;
    run_nop();
    @(negedge clk);
    chk("post-reset mem_req", 64'(mem_req), 64'd0);
    chk("post-reset StallM", 64'(StallM), 64'd0);
    chk("post-reset ALU_ResultW", ALU_ResultW, 64'd0);
    run_instr(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b011, 64'h4000, 64'd0, 5'd9, 1,
              64'h0123_4567_89AB_CDEF);
    run_nop();
    @(negedge clk);
    chk("LD ReadDataW", ReadDataW, 64'h0123_4567_89AB_CDEF);

    // Random mix of ALU ops, loads and stores
    for (int n = 0; n < 400; n++) begin
      int          kind, nb;
      logic [2:0]  f3;
      logic [63:0] a;
      logic        v;
      kind = $urandom_range(0, 2);
      v    = ($urandom_range(0, 9) != 0);
      f3   = 3'($urandom_range(0, 7));
      a    = {$urandom, $urandom};
      nb   = 1 << f3[1:0];
      if ($urandom_range(0, 3) != 0) a = a & ~64'(nb - 1);
      case (kind)
        0: run_instr(v, 1'($urandom), 1'($urandom), 1'b0, 1'b0, f3, a, {$urandom, $urandom},
                     5'($urandom), 0, 64'd0);
        1: run_instr(v, 1'b1, 1'b1, 1'b1, 1'b0, f3, a, {$urandom, $urandom},
                     5'($urandom), $urandom_range(0, 3), {$urandom, $urandom});
        default: run_instr(v, 1'b0, 1'b0, 1'b0, 1'b1, f3, a, {$urandom, $urandom},
                           5'($urandom), $urandom_range(0, 3), {$urandom, $urandom});
      endcase
    end
    run_nop();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
